// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
// master drives the request side; slave is the arithmetic block.
interface bcd_serial_addsub_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction runs as A + nines(B) + (1 - cin); the final carry is inverted into a borrow.
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input logic                clk,
  input logic                rst_n,
  bcd_serial_addsub_if.slave bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sub_q, sub_d;
  logic            c_q, c_d;
  logic            bad_q, bad_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [3:0]      b_dig;
  logic [4:0]      t;
  logic [3:0]      dig;
  logic            c_nx;
  logic            in_bad;

  function automatic logic has_nonbcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign in_bad = has_nonbcd(bus.a) | has_nonbcd(bus.b);

  // One decimal digit step on the current low digits of the operand shift registers.
  always_comb begin
    b_dig = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t     = {1'b0, a_q[3:0]} + {1'b0, b_dig} + {4'b0000, c_q};
    if (t > 5'd9) begin
      dig  = t[3:0] + 4'd6;
      c_nx = 1'b1;
    end else begin
      dig  = t[3:0];
      c_nx = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    c_d     = c_q;
    bad_d   = bad_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          c_d     = bus.sub ? ~bus.cin : bus.cin;
          bad_d   = in_bad;
          idx_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = c_nx;
        // Result digits enter at the top so digit 0 lands in [3:0] after DIGITS shifts.
        res_d = (res_q >> 4) | (W'(dig) << (W - 4));
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          sum_d   = bad_q ? '0 : res_d;
          cout_d  = bad_q ? 1'b0 : (sub_q ? ~c_nx : c_nx);
          err_d   = bad_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      bad_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4): vector table plus busy/back-to-back/reset
// sequences, all expectations hand-computed in decimal.
module tb_bcd_serial_addsub;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  bcd_serial_addsub_if #(.DIGITS(4)) bus ();

  bcd_serial_addsub #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Presents a request and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called just after the accepting edge; leaves the bench inside the done cycle.
  task automatic wait_done(input string name, input logic [15:0] es, input logic ec,
                           input logic ee);
    int cyc;
    int busy_cnt;
    cyc      = 0;
    busy_cnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, ":latency"}, cyc, 4);
    chk({name, ":busycyc"}, busy_cnt, 4);
    chk({name, ":busy@done"}, bus.busy, 1'b0);
    chk({name, ":sum"}, bus.sum, es);
    chk({name, ":cout"}, bus.cout, ec);
    chk({name, ":err"}, bus.err, ee);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    @(negedge clk);
    issue(v.a, v.b, v.sub, v.cin);
    wait_done(name, v.exp_sum, v.exp_cout, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3]  = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0};
    vecs[4]  = '{16'h0123, 16'h0456, 1'b1, 1'b0, 16'h9667, 1'b1, 1'b0};
    vecs[5]  = '{16'h1000, 16'h0999, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8]  = '{16'h0500, 16'h0250, 1'b1, 1'b1, 16'h0249, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[10] = '{16'h0005, 16'h00F0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy", bus.busy, 1'b0);
    chk("rst:done", bus.done, 1'b0);
    chk("rst:sum", bus.sum, 16'h0000);
    chk("rst:cout", bus.cout, 1'b0);
    chk("rst:err", bus.err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // start re-pulsed while busy with other operands must be ignored.
    @(negedge clk);
    issue(16'h1234, 16'h5678, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h1111;
    bus.sub   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ign:latency", cyc, 2);
    chk("ign:sum", bus.sum, 16'h6912);
    chk("ign:cout", bus.cout, 1'b0);
    @(posedge clk);
    #1;
    chk("ign:busy_after", bus.busy, 1'b0);
    chk("ign:done_after", bus.done, 1'b0);

    // Back-to-back: second start issued during the done cycle.
    @(negedge clk);
    issue(16'h5000, 16'h1234, 1'b1, 1'b0);
    wait_done("b2b1", 16'h3766, 1'b0, 1'b0);
    issue(16'h0042, 16'h0058, 1'b0, 1'b0);
    chk("b2b:accepted", bus.busy, 1'b1);
    chk("b2b:hold", bus.sum, 16'h3766);
    wait_done("b2b2", 16'h0100, 1'b0, 1'b0);

    // Reset during digit 2 of an operation.
    run_vec("pre_rst", vecs[4]);
    @(negedge clk);
    issue(16'h1234, 16'h5678, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst:busy", bus.busy, 1'b0);
    chk("mid_rst:done", bus.done, 1'b0);
    chk("mid_rst:sum", bus.sum, 16'h0000);
    chk("mid_rst:cout", bus.cout, 1'b0);
    chk("mid_rst:err", bus.err, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mid_rst:no_done", bus.done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", '{16'h2000, 16'h0345, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
